// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output stream between NREQ requesters.
// Define STREAM_RR_ARBITER_STATS_EN to add the beat_total / grant_total counters.
module stream_rr_arbiter #(
    parameter int DW        = 6,
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 4,
    localparam int IW       = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IW-1:0]        out_id
`ifdef STREAM_RR_ARBITER_STATS_EN
    ,
    output logic [15:0]          beat_total,
    output logic [15:0]          grant_total
`endif
);

    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg;
    logic [IW-1:0]   grant_reg;
    logic [IW-1:0]   last_grant_reg;
    logic [CW-1:0]   beat_cnt_reg;

    logic [DW-1:0]   req_data_arr [NREQ];
    logic            load;
    logic            has_room;
    logic            xfer;
    logic            any_valid;
    logic [IW-1:0]   winner_next;

    assign load     = !out_valid || out_ready;
    assign has_room = beat_cnt_reg < BURST_LAST;
    assign xfer     = req_valid[grant_reg] && req_ready[grant_reg];

    // Ready depends only on arbiter state and output space, never on the requester's own valid.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_data_arr[gi] = req_data[gi*DW +: DW];
            assign req_ready[gi]    = (state_reg == BUSY) && (grant_reg == IW'(gi)) && load && has_room;
        end
    endgenerate

    // Scan from farthest to nearest so the requester closest after last_grant wins.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        winner_next = last_grant_reg;
        any_valid   = 1'b0;
        idx         = 0;
        cand        = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx  = (int'(last_grant_reg) + k) % NREQ;
            cand = IW'(idx);
            if (req_valid[cand]) begin
                winner_next = cand;
                any_valid   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IW'(NREQ - 1);
            beat_cnt_reg   <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_id         <= '0;
        end else begin
            // The output register drains independently of the arbitration state.
            if (load) begin
                if (xfer) begin
                    out_data  <= req_data_arr[grant_reg];
                    out_id    <= grant_reg;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (any_valid) begin
                        grant_reg      <= winner_next;
                        last_grant_reg <= winner_next;
                        beat_cnt_reg   <= '0;
                        state_reg      <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        if ((beat_cnt_reg + CW'(1)) == BURST_LAST) begin
                            state_reg <= IDLE;
                        end
                    end else if (!req_valid[grant_reg]) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef STREAM_RR_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_total  <= '0;
            grant_total <= '0;
        end else begin
            if (out_valid && out_ready) begin
                beat_total <= beat_total + 16'd1;
            end
            if ((state_reg == IDLE) && any_valid) begin
                grant_total <= grant_total + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed testbench for stream_rr_arbiter (DW=6, NREQ=4, BURST_MAX=4).
// Requesters are modelled as per-lane FIFOs; accepted output beats are logged with their cycle.
module tb_stream_rr_arbiter;

    localparam int DW        = 6;
    localparam int NREQ      = 4;
    localparam int BURST_MAX = 4;
    localparam int IW        = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [DW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [IW-1:0]        out_id;
`ifdef STREAM_RR_ARBITER_STATS_EN
    logic [15:0]          beat_total;
    logic [15:0]          grant_total;
`endif

    always #5 clk = ~clk;

    stream_rr_arbiter #(
        .DW        (DW),
        .NREQ      (NREQ),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id)
`ifdef STREAM_RR_ARBITER_STATS_EN
        ,
        .beat_total  (beat_total),
        .grant_total (grant_total)
`endif
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [DW-1:0]   src_mem [NREQ][16];
    int              src_head [NREQ];
    int              src_tail [NREQ];
    logic [NREQ-1:0] en = '0;

    int              rec_n = 0;
    logic [DW-1:0]   rec_data [64];
    logic [IW-1:0]   rec_id [64];
    int              rec_cyc [64];

    task automatic drive_req();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = en[i] && (src_head[i] < src_tail[i]);
            req_data[i*DW +: DW] = req_valid[i] ? src_mem[i][src_head[i]] : '0;
        end
    endtask

    task automatic push(input int i, input int d);
        src_mem[i][src_tail[i]] = DW'(d);
        src_tail[i] = src_tail[i] + 1;
    endtask

    // One clock: sample handshakes on the falling edge, advance sources after the rising edge.
    task automatic cycle();
        logic [NREQ-1:0] fire;
        logic            ofire;
        @(negedge clk);
        fire  = req_valid & req_ready;
        ofire = out_valid && out_ready;
        if (ofire && rec_n < 64) begin
            rec_data[rec_n] = out_data;
            rec_id[rec_n]   = out_id;
            rec_cyc[rec_n]  = cyc;
            rec_n           = rec_n + 1;
        end
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        for (int i = 0; i < NREQ; i++) begin
            if (fire[i]) src_head[i] = src_head[i] + 1;
        end
        drive_req();
    endtask

    task automatic clear_sources();
        en        = '0;
        out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        drive_req();
        rec_n = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_sources();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic run_until(input int target, input int budget);
        for (int n = 0; n < budget && rec_n < target; n++) cycle();
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_sources();
        for (int i = 0; i < NREQ; i++)
            for (int n = 0; n < 4; n++) push(i, i + 1);
        en = 4'b1111;
        drive_req();
        repeat (2) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
            vectors++;
            if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id: got %0d expected 0", out_id); end
            vectors++;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        end
        rst = 1'b1;
        cyc = 0;
        cycle();
        vectors++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready); end
        cycle();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 6'd1 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_beat: got valid=%0b data=%0d id=%0d expected valid=1 data=1 id=0", out_valid, out_data, out_id);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_async_valid: got %0b expected 0", out_valid); end
        vectors++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_async_ready: got %b expected 0000", req_ready); end
        $display("test_reset done: vectors=%0d miscompares=%0d", vectors, errors);
    endtask

    task automatic test_single();
        do_reset();
        push(1, 5); push(1, 6); push(1, 7);
        en = 4'b0010;
        drive_req();
        repeat (5) cycle();
        vectors++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_release: got req_ready=%b expected 0000", req_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got out_valid=%0b expected 0", out_valid); end
        repeat (3) cycle();
        vectors++;
        if (rec_n !== 3) begin errors++; $display("FAIL single_count: got %0d beats expected 3", rec_n); end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (rec_data[k] !== DW'(5 + k) || rec_id[k] !== 2'd1) begin
                errors++;
                $display("FAIL single_beat[%0d]: got data=%0d id=%0d expected data=%0d id=1", k, rec_data[k], rec_id[k], 5 + k);
            end
        end
        vectors++;
        if (rec_cyc[0] !== 2) begin errors++; $display("FAIL single_latency: got %0d cycles expected 2", rec_cyc[0]); end
        $display("test_single done: vectors=%0d miscompares=%0d", vectors, errors);
    endtask

    task automatic test_round_robin();
        logic [IW-1:0] exp_id;
        logic [DW-1:0] exp_data;
        int            exp_gap;
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int n = 0; n < ((i == 0) ? 8 : 4); n++) push(i, i * 8 + n);
        en = 4'b1111;
        drive_req();
        run_until(20, 60);
        vectors++;
        if (rec_n !== 20) begin errors++; $display("FAIL rr_count: got %0d beats expected 20", rec_n); end
        for (int k = 0; k < 20; k++) begin
            exp_id   = IW'((k / 4) % 4);
            exp_data = DW'(int'(exp_id) * 8 + (k / 16) * 4 + (k % 4));
            vectors++;
            if (rec_id[k] !== exp_id || rec_data[k] !== exp_data) begin
                errors++;
                $display("FAIL rr_beat[%0d]: got id=%0d data=%0d expected id=%0d data=%0d", k, rec_id[k], rec_data[k], exp_id, exp_data);
            end
            if (k > 0) begin
                exp_gap = (k % 4 == 0) ? 2 : 1;
                vectors++;
                if (rec_cyc[k] - rec_cyc[k-1] !== exp_gap) begin
                    errors++;
                    $display("FAIL rr_gap[%0d]: got %0d cycles expected %0d", k, rec_cyc[k] - rec_cyc[k-1], exp_gap);
                end
            end
        end
`ifdef STREAM_RR_ARBITER_STATS_EN
        vectors++;
        if (beat_total !== 16'd20) begin errors++; $display("FAIL rr_beat_total: got %0d expected 20", beat_total); end
        vectors++;
        if (grant_total !== 16'd5) begin errors++; $display("FAIL rr_grant_total: got %0d expected 5", grant_total); end
`endif
        $display("test_round_robin done: vectors=%0d miscompares=%0d", vectors, errors);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int n = 1; n <= 4; n++) push(0, n);
        en = 4'b0001;
        drive_req();
        repeat (3) cycle();
        out_ready = 1'b0;
        #1;
        for (int h = 0; h < 3; h++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 6'd2 || out_id !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%0b data=%0d id=%0d expected valid=1 data=2 id=0", h, out_valid, out_data, out_id);
            end
            vectors++;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", h, req_ready); end
            cycle();
        end
        out_ready = 1'b1;
        run_until(4, 20);
        vectors++;
        if (rec_n !== 4) begin errors++; $display("FAIL bp_count: got %0d beats expected 4", rec_n); end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rec_data[k] !== DW'(k + 1) || rec_id[k] !== 2'd0) begin
                errors++;
                $display("FAIL bp_beat[%0d]: got data=%0d id=%0d expected data=%0d id=0", k, rec_data[k], rec_id[k], k + 1);
            end
        end
        $display("test_backpressure done: vectors=%0d miscompares=%0d", vectors, errors);
    endtask

    task automatic test_early_release();
        int exp_ids  [10] = '{2, 2, 3, 3, 3, 3, 0, 0, 1, 1};
        int exp_vals [10] = '{20, 21, 30, 31, 32, 33, 40, 41, 50, 51};
        do_reset();
        push(2, 20); push(2, 21);
        for (int n = 0; n < 4; n++) push(3, 30 + n);
        push(0, 40); push(0, 41);
        push(1, 50); push(1, 51);
        en = 4'b0100;
        drive_req();
        cycle();
        en = 4'b1111;
        drive_req();
        run_until(10, 80);
        vectors++;
        if (rec_n !== 10) begin errors++; $display("FAIL early_count: got %0d beats expected 10", rec_n); end
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (rec_id[k] !== IW'(exp_ids[k]) || rec_data[k] !== DW'(exp_vals[k])) begin
                errors++;
                $display("FAIL early_beat[%0d]: got id=%0d data=%0d expected id=%0d data=%0d", k, rec_id[k], rec_data[k], exp_ids[k], exp_vals[k]);
            end
        end
        $display("test_early_release done: vectors=%0d miscompares=%0d", vectors, errors);
    endtask

    task automatic test_wrap();
        int exp_ids  [5] = '{3, 0, 0, 3, 3};
        int exp_vals [5] = '{60, 10, 11, 61, 62};
        do_reset();
        push(3, 60);
        en = 4'b1000;
        drive_req();
        repeat (5) cycle();
        vectors++;
        if (rec_n !== 1) begin errors++; $display("FAIL wrap_first_count: got %0d beats expected 1", rec_n); end
        push(0, 10); push(0, 11);
        push(3, 61); push(3, 62);
        en = 4'b1001;
        drive_req();
        run_until(5, 40);
        vectors++;
        if (rec_n !== 5) begin errors++; $display("FAIL wrap_count: got %0d beats expected 5", rec_n); end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (rec_id[k] !== IW'(exp_ids[k]) || rec_data[k] !== DW'(exp_vals[k])) begin
                errors++;
                $display("FAIL wrap_beat[%0d]: got id=%0d data=%0d expected id=%0d data=%0d", k, rec_id[k], rec_data[k], exp_ids[k], exp_vals[k]);
            end
        end
        $display("test_wrap done: vectors=%0d miscompares=%0d", vectors, errors);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_early_release();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
